// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core and the data-memory responder.
// Both directions use a valid/ready handshake; the responder sits on the slave modport.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles, accesses a
// DEPTH-word array (word or byte), then holds the response until the requester takes it.
// Optional build macro DATA_MEM_RESP_SIGNEXT_EN: byte loads sign-extend instead of zero-extend.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Counter preload; unused when LATENCY is 0, guarded to avoid underflow.
    localparam logic [3:0] LAT_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic        do_access;
    logic        acc_write;
    logic        acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [AW-1:0] acc_idx;
    logic        acc_err;
    logic [31:0] cur_word;
    logic [7:0]  cur_byte;
    logic [31:0] byte_ext;
    logic [31:0] acc_rdata;
    logic [31:0] wr_word;
    logic        mem_we;

    // Select the access operands: with LATENCY=0 the access happens on the handshake edge, so
    // the live request fields are used; otherwise the latched copy is used.
    always_comb begin
        if (state_q == StIdle) begin
            acc_write = bus.req_write;
            acc_size  = bus.req_size;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_write = write_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    // Decode the access: fault detection, read data formatting and store-word merge.
    always_comb begin
        acc_idx  = acc_addr[AW+1:2];
        acc_err  = (acc_addr[31:AW+2] != '0) || (!acc_size && (acc_addr[1:0] != 2'b00));
        cur_word = mem[acc_idx];

        unique case (acc_addr[1:0])
            2'd0:    cur_byte = cur_word[7:0];
            2'd1:    cur_byte = cur_word[15:8];
            2'd2:    cur_byte = cur_word[23:16];
            default: cur_byte = cur_word[31:24];
        endcase

`ifdef DATA_MEM_RESP_SIGNEXT_EN
        byte_ext = {{24{cur_byte[7]}}, cur_byte};
`else
        byte_ext = {24'd0, cur_byte};
`endif

        if (acc_err || acc_write) begin
            acc_rdata = 32'd0;
        end else if (acc_size) begin
            acc_rdata = byte_ext;
        end else begin
            acc_rdata = cur_word;
        end

        wr_word = cur_word;
        if (acc_size) begin
            unique case (acc_addr[1:0])
                2'd0:    wr_word[7:0]   = acc_wdata[7:0];
                2'd1:    wr_word[15:8]  = acc_wdata[7:0];
                2'd2:    wr_word[23:16] = acc_wdata[7:0];
                default: wr_word[31:24] = acc_wdata[7:0];
            endcase
        end else begin
            wr_word = acc_wdata;
        end
    end

    // Next-state logic for the request/wait/response sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 0) begin
                        do_access = 1'b1;
                        state_d   = StResp;
                    end else begin
                        cnt_d   = LAT_CNT;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_access) begin
            rdata_d = acc_rdata;
            err_d   = acc_err;
        end
    end

    // Reset gates the write so a store whose access edge falls inside reset is never performed.
    assign mem_we = do_access && acc_write && !acc_err && reset;

    // Control and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Word array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= wr_word;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the processor's data-memory load/store path. It accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It then performs a word or byte access on an internal word array and returns the read data and an error flag over a second valid/ready handshake. It replaces the zero-latency data memory when the core is moved to a stalling memory interface.

Parameters:
DEPTH, 256, number of 32-bit words in the array; must be a power of two.
LATENCY, 2, wait-state cycles between request acceptance and the access; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_size  input  1  0 = word, 1 = byte (same encoding as the decoder size bit).
req_addr  input  32  byte address.
req_wdata  input  32  store data; byte stores use bits [7:0].
rsp_valid  output  1  response present.
rsp_ready  input  1  requester accepts the response.
rsp_rdata  output  32  load data; 0 for stores and on error.
rsp_err  output  1  access faulted; qualified by rsp_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake = req_valid & req_ready at a rising edge.
  - On handshake, latch write, size, addr and wdata into internal registers. Later changes on the req_* inputs have no effect.
  - On handshake with LATENCY>0: go to WAIT and load counter = LATENCY-1.
  - On handshake with LATENCY=0: perform the access on that same edge and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where counter==0: perform the access and go to RESP.
- RESP:
  - req_ready=0, rsp_valid=1.
  - rsp_rdata and rsp_err hold stable until rsp_ready=1 at a rising edge.
  - On that edge: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - A new request is not accepted in the same cycle as the response handshake. Minimum gap is 1 IDLE cycle.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the request handshake edge.
- Address map:
  - Word index = addr[log2(DEPTH)+1:2].
  - In range iff addr < 4*DEPTH (all upper bits zero).
- Error, checked on the latched request:
  - Error if the address is out of range, or if a word access has addr[1:0] != 0.
  - On error: rsp_err=1, rsp_rdata=0, array unchanged.
  - A byte access never faults on alignment.
- Word load: rsp_rdata = array[index].
- Byte load:
  - Lane = addr[1:0], little-endian (lane 0 = bits [7:0]).
  - Returned in rsp_rdata[7:0]; upper bits per Optional Feature.
- Word store: array[index] = wdata.
- Byte store: only the lane selected by addr[1:0] is written with wdata[7:0]; other lanes are preserved.
- Store response: rsp_rdata=0, rsp_err=0 unless faulted.
- Back-pressure: no limit on cycles spent in RESP. No second request is queued.
- Reset asserted mid-WAIT or mid-RESP:
  - The in-flight response is dropped.
  - A store whose access edge has not yet occurred is not performed.
  - A completed store remains in the array.

Optional Feature:
Macro: DATA_MEM_RESP_SIGNEXT_EN.
- Defined: byte loads sign-extend, so rsp_rdata[31:8] = copies of bit 7.
- Undefined: byte loads zero-extend, so rsp_rdata[31:8] = 0.
- Word loads, stores and errors are identical in both builds.

Test Plan:
All scenarios use LATENCY=2 and DEPTH=256 unless stated.
1. Word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 -> load rsp_valid rises 3 cycles after its handshake; rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte store addr=0x11, wdata=0x000000A5 over 0xDEADBEEF, then word load 0x10 -> 0xDEADA5EF. Byte load 0x11 -> 0xFFFFFFA5 with DATA_MEM_RESP_SIGNEXT_EN, 0x000000A5 without.
3. Word load addr=0x13 (misaligned), then word store addr=0x400 (out of range) -> each gives rsp_err=1, rsp_rdata=0; a following word load of 0x10 shows the array unchanged.
4. Hold rsp_ready=0 for 5 cycles after rsp_valid, with req_valid=1 the whole time -> req_ready=0 and rsp_rdata stable throughout. The response completes on the first rsp_ready=1 edge, and the next request is accepted one cycle later.
5. Word store to 0x20 with reset pulled low during WAIT -> outputs return to reset values immediately; after release, word load 0x20 returns the old value. With LATENCY=0, load rsp_valid rises 1 cycle after the handshake.
